// File: rtl/spm_line_xfer.sv
// Line-to-word transfer initiator for one SPM request port.
// A line read or write from a line-granular master is split into XLEN-wide word
// requests on a dcache-style request/response pair. The word responses are
// gathered and one line-level completion pulse is returned.
// The package holds the port structs so the file is self-contained.

package spm_line_xfer_pkg;

  localparam int XLEN               = 64;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;

  // Word request toward the SPM controller.
  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  // Word response from the SPM controller.
  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } xfer_state_e;

endpackage

// Handshakes:
//  - Line side: a request is taken on a cycle where line_req_i and line_ready_o
//    are both high; the master must hold its fields stable until then. The
//    completion is a one-cycle line_valid_o pulse with no back-pressure.
//  - Word side: data_req and every request field are registered and held until
//    the word completes. A write completes on data_gnt, a read on data_rvalid;
//    the other signal is ignored, as is any response while data_req is low.
module spm_line_xfer
  import spm_line_xfer_pkg::*;
#(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 64,
  parameter int IDX_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    line_req_i,
  output logic                    line_ready_o,
  input  logic                    line_we_i,
  input  logic [ADDR_WIDTH-1:0]   line_addr_i,
  input  logic [LINE_WIDTH-1:0]   line_wdata_i,
  input  logic [LINE_WIDTH/8-1:0] line_be_i,
  output logic                    line_valid_o,
  output logic [LINE_WIDTH-1:0]   line_rdata_o,
  output logic                    line_err_o,
  output dcache_req_i_t           spm_req_o,
  input  dcache_req_o_t           spm_req_i,
  output xfer_state_e             dbg_state_o
);

  localparam int N_WORDS   = LINE_WIDTH / XLEN;
  localparam int XB        = XLEN / 8;
  localparam int BE_W      = LINE_WIDTH / 8;
  localparam int KW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BYTE_BITS = $clog2(XB);
  localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [TW-1:0]        TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [XLEN-1:0]      BAD_WORD  = XLEN'(64'hCA11AB1E_BADCAB1E);
  localparam logic [IDX_WIDTH-1:0] LINE_MASK = IDX_WIDTH'(BE_W - 1);

  // Lowest word index >= start whose byte-enable slice is nonzero; MSB = found.
  function automatic logic [KW:0] find_word(input logic [BE_W-1:0] be, input int start);
    logic [KW:0] res;
    res = '0;
    for (int j = N_WORDS - 1; j >= 0; j--) begin
      if (j >= start && (|be[j*XB +: XB])) begin
        res = {1'b1, KW'(j)};
      end
    end
    return res;
  endfunction

  // Full word request for word k of the line described by base/tag/we/wdata/be.
  function automatic dcache_req_i_t word_req(input logic [IDX_WIDTH-1:0]        base,
                                             input logic [DCACHE_TAG_WIDTH-1:0] tag,
                                             input logic                        we,
                                             input logic [LINE_WIDTH-1:0]       wdata,
                                             input logic [BE_W-1:0]             be,
                                             input logic [KW-1:0]               k);
    dcache_req_i_t r;
    logic [IDX_WIDTH-1:0] idx;
    r               = '0;
    idx             = base | (IDX_WIDTH'(k) << BYTE_BITS);
    r.address_index = DCACHE_INDEX_WIDTH'(idx);
    r.address_tag   = tag;
    r.data_wdata    = wdata[k*XLEN +: XLEN];
    r.data_req      = 1'b1;
    r.data_we       = we;
    r.data_be       = we ? be[k*XB +: XB] : '1;
    r.data_size     = 2'(BYTE_BITS);
    r.kill_req      = 1'b0;
    r.tag_valid     = 1'b1;
    return r;
  endfunction

  xfer_state_e                 state_q, state_d;
  logic                        we_q;
  logic [IDX_WIDTH-1:0]        base_q;
  logic [DCACHE_TAG_WIDTH-1:0] tag_q;
  logic [LINE_WIDTH-1:0]       wdata_q;
  logic [BE_W-1:0]             be_q;
  logic [LINE_WIDTH-1:0]       rdata_q;
  logic                        err_q;
  logic [KW-1:0]               k_q;
  logic [TW-1:0]               tmo_q;
  dcache_req_i_t               req_q;

  logic                        accept;
  logic                        word_done;
  logic                        tmo_fire;
  logic [KW:0]                 first_w;
  logic [KW:0]                 next_w;
  logic [IDX_WIDTH-1:0]        in_base;
  logic [DCACHE_TAG_WIDTH-1:0] in_tag;

  // Event decode: accept, word completion, timeout, and word selection.
  always_comb begin
    accept    = line_req_i && (state_q == S_IDLE);
    in_base   = line_addr_i[IDX_WIDTH-1:0] & ~LINE_MASK;
    in_tag    = DCACHE_TAG_WIDTH'(line_addr_i >> IDX_WIDTH);
    first_w   = line_we_i ? find_word(line_be_i, 0) : {1'b1, KW'(0)};
    word_done = (state_q == S_ISSUE) && req_q.data_req &&
                (we_q ? spm_req_i.data_gnt : spm_req_i.data_rvalid);
    if (we_q) begin
      next_w = find_word(be_q, int'(k_q) + 1);
    end else if (int'(k_q) + 1 < N_WORDS) begin
      next_w = {1'b1, KW'(int'(k_q) + 1)};
    end else begin
      next_w = '0;
    end
    // A completion in the same cycle wins over the timeout.
    tmo_fire = (TIMEOUT_CYCLES != 0) && (state_q == S_ISSUE) && !word_done &&
               (tmo_q == TMO_LAST);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> DONE -> IDLE, zero-enable writes skip ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = first_w[KW] ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (word_done && !next_w[KW]) begin
          state_d = S_DONE;
        end else if (tmo_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line context, word request register, read buffer, error and timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      k_q     <= '0;
      tmo_q   <= '0;
      req_q   <= '0;
    end else if (accept) begin
      we_q    <= line_we_i;
      base_q  <= in_base;
      tag_q   <= in_tag;
      wdata_q <= line_wdata_i;
      be_q    <= line_be_i;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      k_q     <= first_w[KW-1:0];
      if (first_w[KW]) begin
        req_q <= word_req(in_base, in_tag, line_we_i, line_wdata_i, line_be_i, first_w[KW-1:0]);
      end else begin
        req_q <= '0;
      end
    end else if (state_q == S_ISSUE) begin
      if (word_done) begin
        tmo_q <= '0;
        if (!we_q) begin
          rdata_q[k_q*XLEN +: XLEN] <= spm_req_i.data_rdata;
          if (spm_req_i.data_rdata == BAD_WORD) begin
            err_q <= 1'b1;
          end
        end
        if (next_w[KW]) begin
          // Back-to-back issue: the responder is idle again once it has answered.
          k_q   <= next_w[KW-1:0];
          req_q <= word_req(base_q, tag_q, we_q, wdata_q, be_q, next_w[KW-1:0]);
        end else begin
          req_q <= '0;
        end
      end else if (tmo_fire) begin
        // Abandon the remaining words; unread words stay zero.
        req_q <= '0;
        err_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign line_ready_o = (state_q == S_IDLE);
  assign line_valid_o = (state_q == S_DONE);
  assign line_err_o   = line_valid_o && err_q;
  assign line_rdata_o = rdata_q;
  assign spm_req_o    = req_q;
  assign dbg_state_o  = state_q;

endmodule
